// File: rtl/line_fetch_scheduler_if.sv
// Mover job interface between the line fetch scheduler and the AXI data mover.
//
// Handshake (level based, not valid/ready):
//   en         - scheduler holds high while a job is offered; src_addr,
//                dest_addr and length are stable for as long as en is high.
//   done       - mover status: high = idle/complete, low = job in progress.
//                A job counts as taken once done is seen low while en is high.
//                The job is finished once done returns high.
//
// Ports:
//   src_addr   - job source byte address (framebuffer)
//   dest_addr  - job destination byte address (line buffer)
//   length     - job length in bytes
interface line_fetch_scheduler_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dest_addr;
  logic [ADDR_WIDTH-1:0] length;
  logic                  done;

  modport master (output en, src_addr, dest_addr, length, input done);
  modport slave  (input en, src_addr, dest_addr, length, output done);
endinterface

// File: rtl/line_fetch_scheduler.sv
// line_fetch_scheduler
// Takes one line request per scanline and works out the framebuffer source
// address. It splits the line into mover jobs of at most CHUNK_BYTES and
// alternates lines between the two line-buffer halves.
//
// Ports:
//   aclk, aresetn    - clock, asynchronous active-low reset
//   enable           - scheduler enable (level)
//   cfg_base/bpl/line_bytes/height - frame geometry, sampled on line acceptance
//   frame_start      - pulse, restart at line 0 (deferred while a line is in flight)
//   line_req         - pulse, fetch the next line
//   mover            - job interface to the data mover (master side)
//   busy             - a line fetch is in progress
//   line_ready       - pulse, line fully written (or an empty/out-of-frame request)
//   line_buf         - half of the last completed line
//   underrun         - sticky, a line_req was dropped; cleared by underrun_clr
//   dbg_state        - current FSM state
module line_fetch_scheduler #(
  parameter int ADDR_WIDTH  = 64,
  parameter int CHUNK_BYTES = 512,
  parameter int BUF_OFFSET  = 16384
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [63:0] cfg_base,
  input  logic [13:0] cfg_bpl,
  input  logic [14:0] cfg_line_bytes,
  input  logic [11:0] cfg_height,
  input  logic        frame_start,
  input  logic        line_req,
  line_fetch_scheduler_if.master mover,
  output logic        busy,
  output logic        line_ready,
  output logic        line_buf,
  output logic        underrun,
  input  logic        underrun_clr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [14:0] CHUNK_LEN = 15'(CHUNK_BYTES);

  state_t                state_q, state_d;
  logic [63:0]           line_addr_q;
  logic [11:0]           line_idx_q;
  logic                  buf_sel_q;
  logic                  cur_buf_q;
  logic [14:0]           rem_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic                  pend_q;
  logic                  line_ready_q, line_buf_q, underrun_q;

  logic        idle_restart, accept, drop, fetch_ok, cancel, last_chunk;
  logic [63:0] eff_addr;
  logic [11:0] eff_idx;
  logic        eff_buf;
  logic [14:0] chunk_len, rem_after;

  // A restart (new or deferred) takes effect before a same-cycle request.
  assign idle_restart = (state_q == S_IDLE) && (frame_start || pend_q);
  assign eff_addr     = idle_restart ? cfg_base : line_addr_q;
  assign eff_idx      = idle_restart ? 12'd0 : line_idx_q;
  assign eff_buf      = idle_restart ? 1'b0 : buf_sel_q;
  assign fetch_ok     = (eff_idx < cfg_height) && (cfg_line_bytes != 15'd0);
  assign accept       = (state_q == S_IDLE) && enable && line_req;
  assign drop         = (state_q != S_IDLE) && enable && line_req;

  assign chunk_len  = (rem_q > CHUNK_LEN) ? CHUNK_LEN : rem_q;
  assign rem_after  = rem_q - chunk_len;
  assign last_chunk = (rem_after == 15'd0);
  // Remaining chunks are abandoned at a chunk boundary when a restart is
  // pending or the scheduler is disabled; the chunk in flight always finishes.
  assign cancel     = pend_q || frame_start || !enable;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && fetch_ok) state_d = S_ISSUE;
      S_ISSUE: if (!mover.done) state_d = S_WAIT;
      S_WAIT: begin
        if (mover.done) begin
          if (cancel)          state_d = S_IDLE;
          else if (last_chunk) state_d = S_DONE;
          else                 state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      line_addr_q  <= '0;
      line_idx_q   <= '0;
      buf_sel_q    <= 1'b0;
      cur_buf_q    <= 1'b0;
      rem_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      pend_q       <= 1'b0;
      line_ready_q <= 1'b0;
      line_buf_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_ready_q <= 1'b0;

      if (state_q == S_IDLE) begin
        if (idle_restart) begin
          line_addr_q <= cfg_base;
          line_idx_q  <= '0;
          buf_sel_q   <= 1'b0;
          pend_q      <= 1'b0;
        end
        if (accept) begin
          if (fetch_ok) begin
            src_q       <= ADDR_WIDTH'(eff_addr);
            dst_q       <= eff_buf ? ADDR_WIDTH'(BUF_OFFSET) : '0;
            rem_q       <= cfg_line_bytes;
            cur_buf_q   <= eff_buf;
            line_addr_q <= eff_addr + 64'(cfg_bpl);
            line_idx_q  <= eff_idx + 12'd1;
            buf_sel_q   <= ~eff_buf;
          end else begin
            // Empty or out-of-frame line: acknowledge without a mover job.
            line_ready_q <= 1'b1;
          end
        end
      end else begin
        if (frame_start) pend_q <= 1'b1;
        // A dropped line still consumes its address and half so later
        // lines land where the display expects them.
        if (drop && (line_idx_q < cfg_height) && (cfg_line_bytes != 15'd0)) begin
          line_addr_q <= line_addr_q + 64'(cfg_bpl);
          line_idx_q  <= line_idx_q + 12'd1;
          buf_sel_q   <= ~buf_sel_q;
        end
      end

      if ((state_q == S_WAIT) && mover.done && !cancel) begin
        src_q <= src_q + ADDR_WIDTH'(chunk_len);
        dst_q <= dst_q + ADDR_WIDTH'(chunk_len);
        rem_q <= rem_after;
        if (last_chunk) begin
          line_ready_q <= 1'b1;
          line_buf_q   <= cur_buf_q;
        end
      end

      if (drop)              underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
    end
  end

  assign mover.en        = (state_q == S_ISSUE);
  assign mover.src_addr  = src_q;
  assign mover.dest_addr = dst_q;
  assign mover.length    = ADDR_WIDTH'(chunk_len);
  assign busy            = (state_q != S_IDLE);
  assign line_ready      = line_ready_q;
  assign line_buf        = line_buf_q;
  assign underrun        = underrun_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
module tb_line_fetch_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [63:0] cfg_base;
  logic [13:0] cfg_bpl;
  logic [14:0] cfg_line_bytes;
  logic [11:0] cfg_height;
  logic        frame_start;
  logic        line_req;
  logic        busy, line_ready, line_buf, underrun, underrun_clr;
  logic [1:0]  dbg_state;

  line_fetch_scheduler_if #(.ADDR_WIDTH(64)) mif ();

  line_fetch_scheduler dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .enable         (enable),
    .cfg_base       (cfg_base),
    .cfg_bpl        (cfg_bpl),
    .cfg_line_bytes (cfg_line_bytes),
    .cfg_height     (cfg_height),
    .frame_start    (frame_start),
    .line_req       (line_req),
    .mover          (mif.master),
    .busy           (busy),
    .line_ready     (line_ready),
    .line_buf       (line_buf),
    .underrun       (underrun),
    .underrun_clr   (underrun_clr),
    .dbg_state      (dbg_state)
  );

  // clock
  always #5 aclk = ~aclk;

  localparam logic [63:0] BASE = 64'h8000_0000;

  int checks = 0;
  int errors = 0;

  // mover model and monitor
  int          mv_lat = 0;
  int          mv_busy = 2;
  int          mv_state = 0;
  int          mv_cnt = 0;
  int          neg_idx = 0;
  int          last_rise = 0;
  int          cur_encyc = 0;
  int          stable_err = 0;
  int          lr_cnt = 0;
  logic [63:0] job_src[$];
  logic [63:0] job_dst[$];
  logic [63:0] job_len[$];
  int          job_gap[$];
  int          job_encyc[$];
  logic        lr_buf_q[$];
  logic [63:0] s_src, s_dst, s_len;

  always @(negedge aclk) begin
    neg_idx = neg_idx + 1;
    if (line_ready) begin
      lr_cnt = lr_cnt + 1;
      lr_buf_q.push_back(line_buf);
    end
    if (!aresetn) begin
      mv_state = 0;
      mif.done = 1'b1;
    end else begin
      case (mv_state)
        0: if (mif.en) begin
          job_src.push_back(mif.src_addr);
          job_dst.push_back(mif.dest_addr);
          job_len.push_back(mif.length);
          job_gap.push_back(neg_idx - last_rise);
          s_src = mif.src_addr;
          s_dst = mif.dest_addr;
          s_len = mif.length;
          cur_encyc = 1;
          if (mv_lat == 0) begin
            mif.done = 1'b0;
            job_encyc.push_back(cur_encyc);
            mv_cnt = mv_busy;
            mv_state = 2;
          end else begin
            mv_cnt = mv_lat;
            mv_state = 1;
          end
        end
        1: begin
          if (mif.en) begin
            cur_encyc = cur_encyc + 1;
            if (mif.src_addr !== s_src || mif.dest_addr !== s_dst || mif.length !== s_len)
              stable_err = stable_err + 1;
          end
          mv_cnt = mv_cnt - 1;
          if (mv_cnt == 0) begin
            mif.done = 1'b0;
            job_encyc.push_back(cur_encyc);
            mv_cnt = mv_busy;
            mv_state = 2;
          end
        end
        default: begin
          mv_cnt = mv_cnt - 1;
          if (mv_cnt == 0) begin
            mif.done = 1'b1;
            last_rise = neg_idx;
            mv_state = 0;
          end
        end
      endcase
    end
  end

  // driver / checker tasks
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  task automatic pulse_req();
    line_req = 1'b1;
    @(negedge aclk);
    line_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge aclk);
    frame_start = 1'b0;
  endtask

  task automatic clear_mon();
    job_src.delete();
    job_dst.delete();
    job_len.delete();
    job_gap.delete();
    job_encyc.delete();
    lr_buf_q.delete();
    lr_cnt = 0;
    stable_err = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    assert (ok) else begin
      errors = errors + 1;
      $error("FAIL %s_timeout observed=busy expected=idle", tag);
    end
  endtask

  task automatic wait_jobs(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge aclk);
      if (job_src.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    assert (ok) else begin
      errors = errors + 1;
      $error("FAIL wait_jobs_timeout observed=%0d expected=%0d", job_src.size(), n);
    end
  endtask

  initial begin
    aresetn        = 1'b0;
    enable         = 1'b0;
    cfg_base       = BASE;
    cfg_bpl        = 14'd2048;
    cfg_line_bytes = 15'd2560;
    cfg_height     = 12'd100;
    frame_start    = 1'b0;
    line_req       = 1'b0;
    underrun_clr   = 1'b0;
    tick(3);

    // reset state
    chk("rst_en",   64'(mif.en), 64'd0);
    chk("rst_src",  mif.src_addr, 64'd0);
    chk("rst_len",  mif.length, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lr",   64'(line_ready), 64'd0);
    chk("rst_ur",   64'(underrun), 64'd0);
    aresetn = 1'b1;
    enable  = 1'b1;
    tick(2);

    // basic line fetch, line 0
    pulse_frame();
    clear_mon();
    pulse_req();
    chk("l0_busy_n1", 64'(busy), 64'd1);
    chk("l0_en_n1",   64'(mif.en), 64'd1);
    chk("l0_src_n1",  mif.src_addr, BASE);
    chk("l0_len_n1",  mif.length, 64'd512);
    wait_idle("l0");
    chk("l0_njobs", 64'(job_src.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("l0_src%0d", i), job_src[i], BASE + 64'(512 * i));
      chk($sformatf("l0_dst%0d", i), job_dst[i], 64'(512 * i));
      chk($sformatf("l0_len%0d", i), job_len[i], 64'd512);
    end
    chk("l0_lr_cnt", 64'(lr_cnt), 64'd1);
    chk("l0_lr_buf", 64'(lr_buf_q[0]), 64'd0);

    // line 1, accepted in the cycle busy drops
    clear_mon();
    pulse_req();
    wait_idle("l1");
    chk("l1_njobs", 64'(job_src.size()), 64'd5);
    chk("l1_src0",  job_src[0], 64'h8000_0800);
    chk("l1_dst0",  job_dst[0], 64'd16384);
    chk("l1_dst4",  job_dst[4], 64'd16384 + 64'd2048);
    chk("l1_lr_buf", 64'(lr_buf_q[0]), 64'd1);

    // handshake: done stays high 3 cycles after en
    mv_lat = 3;
    clear_mon();
    pulse_req();
    wait_idle("hs");
    chk("hs_njobs",  64'(job_src.size()), 64'd5);
    chk("hs_src0",   job_src[0], 64'h8000_1000);
    chk("hs_en_cyc", 64'(job_encyc[0]), 64'd4);
    chk("hs_gap",    64'(job_gap[1]), 64'd1);
    chk("hs_stable", 64'(stable_err), 64'd0);
    mv_lat = 0;

    // underrun: drop line 1 during line 0
    pulse_frame();
    clear_mon();
    pulse_req();
    tick(3);
    chk("ur_busy", 64'(busy), 64'd1);
    pulse_req();
    chk("ur_set", 64'(underrun), 64'd1);
    wait_idle("ur");
    chk("ur_njobs", 64'(job_src.size()), 64'd5);
    chk("ur_lr_cnt", 64'(lr_cnt), 64'd1);
    clear_mon();
    pulse_req();
    wait_idle("ur_next");
    chk("ur_next_src", job_src[0], BASE + 64'd4096);
    chk("ur_next_dst", job_dst[0], 64'd0);
    chk("ur_next_buf", 64'(lr_buf_q[0]), 64'd0);
    chk("ur_sticky", 64'(underrun), 64'd1);
    // clear colliding with a new drop keeps the flag
    clear_mon();
    pulse_req();
    tick(3);
    line_req     = 1'b1;
    underrun_clr = 1'b1;
    tick(1);
    line_req     = 1'b0;
    underrun_clr = 1'b0;
    chk("ur_clr_vs_drop", 64'(underrun), 64'd1);
    wait_idle("ur_coll");
    underrun_clr = 1'b1;
    tick(1);
    underrun_clr = 1'b0;
    chk("ur_clr", 64'(underrun), 64'd0);

    // frame restart during chunk 2 of 5
    pulse_frame();
    clear_mon();
    pulse_req();
    wait_jobs(2);
    pulse_frame();
    wait_idle("fs");
    tick(2);
    chk("fs_njobs",  64'(job_src.size()), 64'd2);
    chk("fs_src1",   job_src[1], BASE + 64'd512);
    chk("fs_no_lr",  64'(lr_cnt), 64'd0);
    clear_mon();
    pulse_req();
    wait_idle("fs_next");
    chk("fs_next_src", job_src[0], BASE);
    chk("fs_next_dst", job_dst[0], 64'd0);
    chk("fs_next_buf", 64'(lr_buf_q[0]), 64'd0);

    // line_req ignored while disabled
    enable = 1'b0;
    tick(1);
    clear_mon();
    pulse_req();
    chk("dis_lr",   64'(line_ready), 64'd0);
    chk("dis_busy", 64'(busy), 64'd0);
    chk("dis_ur",   64'(underrun), 64'd0);

    // zero-length line
    cfg_line_bytes = 15'd0;
    enable = 1'b1;
    tick(1);
    clear_mon();
    pulse_req();
    chk("zl_lr",   64'(line_ready), 64'd1);
    chk("zl_busy", 64'(busy), 64'd0);
    chk("zl_en",   64'(mif.en), 64'd0);
    tick(1);
    chk("zl_lr_pulse", 64'(line_ready), 64'd0);
    chk("zl_njobs", 64'(job_src.size()), 64'd0);

    // height 2: third request is out of frame
    enable = 1'b0;
    cfg_line_bytes = 15'd64;
    cfg_height = 12'd2;
    enable = 1'b1;
    pulse_frame();
    clear_mon();
    pulse_req();
    wait_idle("h0");
    pulse_req();
    wait_idle("h1");
    pulse_req();
    chk("h2_lr",   64'(line_ready), 64'd1);
    chk("h2_busy", 64'(busy), 64'd0);
    tick(2);
    chk("h2_njobs", 64'(job_src.size()), 64'd2);

    // 520-byte line: 512 + 8
    enable = 1'b0;
    cfg_height = 12'd100;
    cfg_line_bytes = 15'd520;
    enable = 1'b1;
    pulse_frame();
    clear_mon();
    pulse_req();
    wait_idle("b520");
    chk("b520_njobs", 64'(job_src.size()), 64'd2);
    chk("b520_len0",  job_len[0], 64'd512);
    chk("b520_len1",  job_len[1], 64'd8);
    chk("b520_src1",  job_src[1], BASE + 64'd512);
    chk("b520_dst1",  job_dst[1], 64'd512);

    // reset mid-operation
    cfg_line_bytes = 15'd2560;
    clear_mon();
    pulse_req();
    chk("rm_en_before", 64'(mif.en), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("rm_en",   64'(mif.en), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_src",  mif.src_addr, 64'd0);
    chk("rm_len",  mif.length, 64'd0);
    tick(2);
    aresetn = 1'b1;
    tick(1);
    clear_mon();
    pulse_req();
    wait_idle("rm_next");
    chk("rm_next_src", job_src[0], 64'd0);
    chk("rm_next_dst", job_dst[0], 64'd0);
    chk("rm_next_njobs", 64'(job_src.size()), 64'd5);
    chk("rm_next_buf", 64'(lr_buf_q[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
